matmul_mac_engine: RTL and testbench
====================================

# matmul_mac_engine

Downstream consumer of the 3-bit step counter in the 2x2 matrix multiplier. On each enabled step code it performs one multiply-accumulate of C = A x B. It tracks which of the 8 product terms have been applied and raises `done` once all 8 are in. Completion does not depend on the counter's step ordering, so any sequence that visits every code 0..7 exactly once produces the correct result.

## Interface
Parameters:
- `W`, default 8: unsigned element width of A and B.
- `AW`, fixed at 2*W+1 (derived, not overridable): accumulator / result element width.

Ports:
- `clk` input, 1: single clock; all state updates on the rising edge.
- `mr` input, 1: asynchronous, active-low reset.
- `load` input, 1: latch operands, clear accumulators and term mask, start a new product.
- `a_flat` input, 4*W: A elements; element (r,c) at slice [(2r+c)*W +: W].
- `b_flat` input, 4*W: B elements, same packing.
- `ce` input, 1: step valid (same enable that drives the counter).
- `step` input, 3: step code from the counter.
- `c_flat` output, 4*AW: C accumulators; element (r,c) at [(2r+c)*AW +: AW].
- `done` output, 1: all 8 terms accumulated; `c_flat` is final.
- `err` output, 1: sticky; a step code arrived whose term was already applied.

## Operation
- States: IDLE, RUN, DONE.
- Step decode for k = step: r = k[2], c = k[1], j = k[0]. The term is C[r][c] += A[r][j] * B[j][c].
- Arithmetic: unsigned. Product is 2W bits, sum of two products is AW bits, so no overflow is possible.
- IDLE:
  - `ce` is ignored.
  - `load` latches A and B, zeroes all C, clears mask and `err`, and moves to RUN.
- RUN, on `ce`=1:
  - If mask[k]=0: accumulate the term into C[r][c] and set mask[k].
  - If mask[k]=1: no accumulation; set `err`.
  - When the mask becomes 0xFF, move to DONE.
- DONE:
  - `done`=1; C holds the result.
  - `ce` is ignored; `err` is not set.
  - `load` starts a new product (goes to RUN, `done` falls).
- `load` and `ce` in the same cycle: `load` wins and the step is discarded, in every state.
- `load` in RUN: abort and restart with the new operands. `err` is cleared.
- Operands are sampled only on `load`; `a_flat`/`b_flat` may change freely afterwards.

## Timing
- Reset (`mr`=0, asynchronous):
  - state IDLE, `c_flat`=0, mask=0, `done`=0, `err`=0.
  - These values are held while `mr` is low.
  - Reset mid-RUN discards partial sums immediately.
- One accumulation per `ce` cycle. The updated C element is visible the cycle after the `ce` edge.
- `done` rises on the same edge that writes the 8th term, so it is visible together with the final C value.
  - Minimum latency from `load`: 1 cycle to RUN, then 8 `ce` cycles. `done` is high after the 8th step's edge.
- `err` rises on the edge that samples the duplicate step. It stays high until the next `load` or reset.
- `done` stays high until the next `load` or reset.
- No back-pressure: every `ce` pulse in RUN is consumed.

## Structure
- Shared package `matmul_pkg`:
  - state encoding constants (IDLE, RUN, DONE).
  - `W`/`AW` defaults.
  - step-decode function (k -> r, c, j).
  - packing index helper (2r+c).
- Sub-module `mac_cell`:
  - Inputs: `clk`, `mr`, `clr`, `en`, two W-bit operands. Output: AW-bit accumulator.
  - Four instances, one per C element.
  - The engine routes the selected A/B elements to the cell addressed by (r,c).
- Top holds the FSM, operand registers, 8-bit term mask and sticky `err`.

## Test plan
- In-order steps, A=[1 2;3 4], B=[5 6;7 8]: `load`, then `ce` with steps 0..7 on consecutive cycles. Required: C=[19 22;43 50], `done`=1 after the 8th edge, `err`=0.
- Out-of-order, same operands: steps 7,2,0,5,1,6,3,4. Required: identical C. `done` must not rise before the last step.
- Duplicate step: steps 0,1,2,2,3,4,5,6,7. Required: `err`=1 from the 4th edge onward; C=[19 22;43 50]; `done` after step 7.
- Max values, W=8, A=B=all 255: steps 0..7. Required: every C element = 130050 (0x1FC02).
- Reset mid-run: assert `mr`=0 after 4 steps. Required: all C=0 and `done`=0 immediately. A fresh `load` plus 8 steps then gives the correct result.
- `load` collision: `load` and `ce` in the same cycle during RUN, with new A=identity, B=[5 6;7 8]. Required: that step is discarded, the mask restarts, and after 8 more steps C=[5 6;7 8].

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the 2x2 matrix-multiply MAC engine.
package matmul_pkg;

    localparam int unsigned W_DEF  = 8;
    localparam int unsigned AW_DEF = 2 * W_DEF + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef struct packed {
        logic r;
        logic c;
        logic j;
    } step_t;

    // Step code k selects C[k[2]][k[1]] += A[k[2]][k[0]] * B[k[0]][k[1]].
    function automatic step_t decode_step(input logic [2:0] k);
        step_t s;
        s.r = k[2];
        s.c = k[1];
        s.j = k[0];
        return s;
    endfunction

    function automatic logic [1:0] elem_idx(input logic r, input logic c);
        return {r, c};
    endfunction

endpackage

// File: rtl/matmul_mac_engine_if.sv
// Operand/step/result bundle between the step source and the MAC engine.
interface matmul_mac_engine_if #(
    parameter int unsigned W = matmul_pkg::W_DEF
);
    localparam int unsigned AW = 2 * W + 1;

    logic            load;
    logic [4*W-1:0]  a_flat;
    logic [4*W-1:0]  b_flat;
    logic            ce;
    logic [2:0]      step;
    logic [4*AW-1:0] c_flat;
    logic            done;
    logic            err;

    modport master (
        output load, a_flat, b_flat, ce, step,
        input  c_flat, done, err
    );

    modport slave (
        input  load, a_flat, b_flat, ce, step,
        output c_flat, done, err
    );

endinterface

// File: rtl/mac_cell.sv
// One C element: clearable unsigned multiply-accumulate register.
module mac_cell #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         mr,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [2*W:0] acc
);

    logic [2*W-1:0] prod;

    always_comb begin
        prod = (2 * W)'(op_a) * (2 * W)'(op_b);
    end

    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + (2 * W + 1)'(prod);
        end
    end

endmodule

// File: rtl/matmul_mac_engine.sv
// 2x2 matrix-multiply engine: one product term per enabled step code, done once all 8 are in.
module matmul_mac_engine
    import matmul_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input logic               clk,
    input logic               mr,
    matmul_mac_engine_if.slave bus
);

    state_e         state_q;
    logic [4*W-1:0] a_q;
    logic [4*W-1:0] b_q;
    logic [7:0]     mask_q;
    logic [7:0]     mask_next;
    logic           err_q;
    logic           done_q;

    logic [W-1:0]   a_el [4];
    logic [W-1:0]   b_el [4];
    logic [2*W:0]   acc  [4];

    step_t          sd;
    logic [1:0]     cell_idx;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           accept;

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign a_el[i] = a_q[i*W +: W];
        assign b_el[i] = b_q[i*W +: W];
    end

    // A load in the same cycle as ce always wins, so the step never reaches a cell.
    always_comb begin
        sd        = decode_step(bus.step);
        cell_idx  = elem_idx(sd.r, sd.c);
        a_sel     = a_el[elem_idx(sd.r, sd.j)];
        b_sel     = b_el[elem_idx(sd.j, sd.c)];
        mask_next = mask_q | (8'b1 << bus.step);
        accept    = (state_q == StRun) && bus.ce && !bus.load && !mask_q[bus.step];
    end

    for (genvar i = 0; i < 4; i++) begin : g_cell
        mac_cell #(
            .W(W)
        ) u_cell (
            .clk (clk),
            .mr  (mr),
            .clr (bus.load),
            .en  (accept && (cell_idx == 2'(i))),
            .op_a(a_sel),
            .op_b(b_sel),
            .acc (acc[i])
        );
    end

    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.load) begin
            state_q <= StRun;
            a_q     <= bus.a_flat;
            b_q     <= bus.b_flat;
            mask_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (bus.ce) begin
                        if (mask_q[bus.step]) begin
                            err_q <= 1'b1;
                        end else begin
                            mask_q <= mask_next;
                            if (&mask_next) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.c_flat = {acc[3], acc[2], acc[1], acc[0]};
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_matmul_mac_engine.sv
// Self-checking bench: vector table, hand-written corner sequences and randomized model run.
module tb_matmul_mac_engine;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 2 * W + 1;

    logic clk = 1'b0;
    logic mr  = 1'b0;

    always #5 clk = ~clk;

    matmul_mac_engine_if #(.W(W)) bus ();

    matmul_mac_engine #(
        .W(W)
    ) dut (
        .clk(clk),
        .mr (mr),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string           name;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [23:0]     ord;
        logic [4*AW-1:0] exp;
    } vec_t;

    vec_t vq[$];

    // Reference: which terms have landed, plus the operands latched at load.
    bit          m_run;
    bit          m_done;
    bit          m_err;
    bit          seen [8];
    int unsigned ma   [4];
    int unsigned mb   [4];

    function void model_reset();
        m_run  = 0;
        m_done = 0;
        m_err  = 0;
        for (int k = 0; k < 8; k++) seen[k] = 0;
        for (int e = 0; e < 4; e++) begin
            ma[e] = 0;
            mb[e] = 0;
        end
    endfunction

    function void model_step(input logic ld, input logic [31:0] a, input logic [31:0] b,
                             input logic ce, input logic [2:0] k);
        bit all_in;
        if (ld) begin
            for (int e = 0; e < 4; e++) begin
                ma[e] = int'(a[e*8 +: 8]);
                mb[e] = int'(b[e*8 +: 8]);
            end
            for (int i = 0; i < 8; i++) seen[i] = 0;
            m_run  = 1;
            m_done = 0;
            m_err  = 0;
        end else if (m_run && ce) begin
            if (seen[k]) begin
                m_err = 1;
            end else begin
                seen[k] = 1;
                all_in  = 1;
                for (int i = 0; i < 8; i++) if (!seen[i]) all_in = 0;
                if (all_in) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end
    endfunction

    // C[r][c] = sum over applied j of A[r][j]*B[j][c].
    function int unsigned model_c(input int e);
        int unsigned sum;
        int r;
        int c;
        r   = e / 2;
        c   = e % 2;
        sum = 0;
        for (int j = 0; j < 2; j++) begin
            if (seen[4*r + 2*c + j]) sum += ma[2*r + j] * mb[2*j + c];
        end
        return sum;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic check_model(input string tag);
        for (int e = 0; e < 4; e++) begin
            check($sformatf("%s c%0d", tag, e), 32'(bus.c_flat[e*AW +: AW]), model_c(e));
        end
        check({tag, " done"}, 32'(bus.done), 32'(m_done));
        check({tag, " err"},  32'(bus.err),  32'(m_err));
    endtask

    task automatic check_c(input string tag, input logic [4*AW-1:0] exp);
        logic [4*AW-1:0] e_v;
        e_v = exp;
        for (int e = 0; e < 4; e++) begin
            check($sformatf("%s c%0d", tag, e), 32'(bus.c_flat[e*AW +: AW]),
                  32'(e_v[e*AW +: AW]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [31:0] a, input logic [31:0] b,
                         input logic ce, input logic [2:0] k);
        bus.load   = ld;
        bus.a_flat = a;
        bus.b_flat = b;
        bus.ce     = ce;
        bus.step   = k;
        tick();
        model_step(ld, a, b, ce, k);
    endtask

    task automatic add_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [23:0] ord, input logic [4*AW-1:0] exp);
        vec_t v;
        v.name = name;
        v.a    = a;
        v.b    = b;
        v.ord  = ord;
        v.exp  = exp;
        vq.push_back(v);
    endtask

    localparam logic [31:0]     A1234 = 32'h04030201;
    localparam logic [31:0]     B5678 = 32'h08070605;
    localparam logic [31:0]     AID   = 32'h01000001;
    localparam logic [4*AW-1:0] C_REF = {17'd50, 17'd43, 17'd22, 17'd19};
    localparam logic [4*AW-1:0] C_ID  = {17'd8, 17'd7, 17'd6, 17'd5};

    initial begin
        logic [2:0] k;
        logic [2:0] dup_seq [9];
        logic       ld;

        bus.load   = 1'b0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        bus.ce     = 1'b0;
        bus.step   = '0;
        model_reset();

        add_vec("inorder",  A1234, B5678, 24'o76543210, C_REF);
        add_vec("shuffled", A1234, B5678, 24'o43615027, C_REF);
        add_vec("maxval",   32'hFFFFFFFF, 32'hFFFFFFFF, 24'o76543210, {4{17'h1FC02}});
        add_vec("identity", AID, B5678, 24'o01234567, C_ID);
        add_vec("diag",     32'h03000002, 32'h01010101, 24'o43615027,
                {17'd3, 17'd3, 17'd2, 17'd2});

        // Reset state, held while mr is low even with load/ce active.
        #2;
        check_c("reset", '0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset err",  32'(bus.err),  32'd0);
        drive(1'b1, A1234, B5678, 1'b1, 3'd0);
        model_reset();
        check_c("reset held", '0);
        check("reset held done", 32'(bus.done), 32'd0);
        mr = 1'b1;

        // ce in IDLE is ignored.
        drive(1'b0, A1234, B5678, 1'b1, 3'd0);
        check_model("idle ce");

        foreach (vq[v]) begin
            drive(1'b1, vq[v].a, vq[v].b, 1'b0, 3'd0);
            check_c({vq[v].name, " load"}, '0);
            check({vq[v].name, " load done"}, 32'(bus.done), 32'd0);
            for (int i = 0; i < 8; i++) begin
                // Operand inputs are scrambled after load; only latched values may count.
                drive(1'b0, $urandom, $urandom, 1'b1, vq[v].ord[3*i +: 3]);
                check($sformatf("%s done@%0d", vq[v].name, i), 32'(bus.done),
                      32'(i == 7));
            end
            check_c(vq[v].name, vq[v].exp);
            check({vq[v].name, " err"}, 32'(bus.err), 32'd0);
        end

        // ce in DONE is ignored and never flags err.
        drive(1'b0, 32'h0, 32'h0, 1'b1, 3'd3);
        check_c("done ce", {17'd3, 17'd3, 17'd2, 17'd2});
        check("done ce done", 32'(bus.done), 32'd1);
        check("done ce err",  32'(bus.err),  32'd0);

        // Duplicate step 2.
        dup_seq = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        drive(1'b1, A1234, B5678, 1'b0, 3'd0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, A1234, B5678, 1'b1, dup_seq[i]);
            check($sformatf("dup err@%0d", i), 32'(bus.err), 32'(i >= 3));
            check($sformatf("dup done@%0d", i), 32'(bus.done), 32'(i == 8));
        end
        check_c("dup", C_REF);

        // Asynchronous reset mid-run.
        drive(1'b1, A1234, B5678, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, A1234, B5678, 1'b1, 3'(i));
        check_model("pre-reset");
        mr = 1'b0;
        #1;
        model_reset();
        check_c("midrst", '0);
        check("midrst done", 32'(bus.done), 32'd0);
        tick();
        mr = 1'b1;
        drive(1'b1, A1234, B5678, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 3'(7 - i));
        check_c("after rst", C_REF);
        check("after rst done", 32'(bus.done), 32'd1);

        // load + ce collision in RUN, with err already raised.
        drive(1'b1, A1234, B5678, 1'b0, 3'd0);
        drive(1'b0, A1234, B5678, 1'b1, 3'd0);
        drive(1'b0, A1234, B5678, 1'b1, 3'd1);
        drive(1'b0, A1234, B5678, 1'b1, 3'd1);
        check("coll pre err", 32'(bus.err), 32'd1);
        drive(1'b1, AID, B5678, 1'b1, 3'd4);
        check_c("coll", '0);
        check("coll err",  32'(bus.err),  32'd0);
        check("coll done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 3'(i));
            check($sformatf("coll done@%0d", i), 32'(bus.done), 32'd0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 3'd7);
        check_c("coll final", C_ID);
        check("coll final done", 32'(bus.done), 32'd1);
        check_model("coll model");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            ld = ($urandom_range(0, 24) == 0) || (!m_run && $urandom_range(0, 3) == 0);
            k  = 3'($urandom_range(0, 7));
            drive(ld, $urandom, $urandom, 1'($urandom_range(0, 3) != 0), k);
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
